// File: rtl/rr_mux8.sv
// ----------------------------------------------------------------------------
// rr_mux8 : 8:1 round-robin merging multiplexer.
//
// Eight valid/ready producer lanes feed one registered output stream. Every
// output beat carries the 3-bit index of the lane it came from, so that a
// downstream 1:8 demux can steer it back.
//
// Parameters
//   DW          data width of each lane and of the output
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active-high
//   in_valid    [7:0]     lane k has a beat pending
//   in_data     [8*DW-1:0] lane k data = in_data[k*DW +: DW]
//   in_ready    [7:0]     one-hot or zero; lane k accepted this cycle
//   out_valid   output register holds a beat
//   out_data    [DW-1:0]  data of the held beat
//   out_sel     [2:0]     source lane of the held beat
//   out_ready   consumer takes the held beat this cycle
//
// Optional feature (macro RR_MUX8_LOCK_EN): packet lock.
//   in_last     [7:0]     lane k beat is the last of its packet
//   out_last    registered last flag of the held beat
//   Once a lane transfers a non-last beat, only that lane is granted until it
//   transfers a last beat.
// ----------------------------------------------------------------------------
module rr_mux8 #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      in_valid,
    input  logic [8*DW-1:0] in_data,
    output logic [7:0]      in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [2:0]      out_sel,
    input  logic            out_ready
`ifdef RR_MUX8_LOCK_EN
    ,
    input  logic [7:0]      in_last,
    output logic            out_last
`endif
);

    logic [2:0]    ptr;
    logic [2:0]    gnt_idx;
    logic [2:0]    cand;
    logic          gnt_any;
    logic          load;
    logic          xfer;
    logic [DW-1:0] lane_data;

`ifdef RR_MUX8_LOCK_EN
    logic          lock;
    logic [2:0]    lock_idx;
`endif

    // Output register can take a new beat when empty or being drained.
    assign load = !out_valid || out_ready;

    // Rotating priority search. Scanning offsets from 7 down to 0 lets the
    // lowest offset from ptr (the highest-priority valid lane) win last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr;
        cand    = ptr;
        for (int i = 7; i >= 0; i--) begin
            cand = ptr + 3'(i);
            if (in_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
`ifdef RR_MUX8_LOCK_EN
        // A locked packet owns the output even while its lane is idle.
        if (lock) begin
            gnt_idx = lock_idx;
            gnt_any = in_valid[lock_idx];
        end
`endif
    end

    assign in_ready  = (gnt_any && load && !rst) ? (8'd1 << gnt_idx) : 8'd0;
    assign xfer      = |(in_valid & in_ready);
    assign lane_data = in_data[gnt_idx*DW +: DW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 3'd0;
            ptr       <= 3'd0;
        end else if (xfer) begin
            // Reload covers both the empty case and drain-plus-reload.
            out_valid <= 1'b1;
            out_data  <= lane_data;
            out_sel   <= gnt_idx;
            ptr       <= gnt_idx + 3'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef RR_MUX8_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock     <= 1'b0;
            lock_idx <= 3'd0;
            out_last <= 1'b0;
        end else if (xfer) begin
            out_last <= in_last[gnt_idx];
            if (in_last[gnt_idx]) begin
                lock <= 1'b0;
            end else begin
                lock     <= 1'b1;
                lock_idx <= gnt_idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux8.sv
// ----------------------------------------------------------------------------
// tb_rr_mux8 : directed, table-driven bench for rr_mux8 (DW = 8).
// Lane k carries data k*8'h11 unless a vector overrides lane 5.
// ----------------------------------------------------------------------------
module tb_rr_mux8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_ready;
`ifdef RR_MUX8_LOCK_EN
    logic [7:0]  in_last;
    logic        out_last;
`endif

    int n_cmp = 0;
    int n_err = 0;

    rr_mux8 #(.DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
`ifdef RR_MUX8_LOCK_EN
        ,
        .in_last   (in_last),
        .out_last  (out_last)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] iv;
        logic       ordy;
        logic [7:0] d5;
        logic [7:0] er;
        logic       ev;
        logic [2:0] es;
        logic [7:0] ed;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] pack(input logic [7:0] d5);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'(k) * 8'h11;
        d[5*8 +: 8] = d5;
        return d;
    endfunction

    task automatic add(input logic r, input logic [7:0] iv, input logic ordy,
                       input logic [7:0] d5, input logic [7:0] er, input logic ev,
                       input logic [2:0] es, input logic [7:0] ed);
        vec_t v;
        v.rst = r; v.iv = iv; v.ordy = ordy; v.d5 = d5;
        v.er = er; v.ev = ev; v.es = es; v.ed = ed;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] er, input logic ev,
                             input logic [2:0] es, input logic [7:0] ed);
        check({tag, " in_ready"},  32'(in_ready),  32'(er));
        check({tag, " out_valid"}, 32'(out_valid), 32'(ev));
        check({tag, " out_sel"},   32'(out_sel),   32'(es));
        check({tag, " out_data"},  32'(out_data),  32'(ed));
    endtask

`ifdef RR_MUX8_LOCK_EN
    task automatic lstep(input string tag, input logic [7:0] iv, input logic [7:0] last,
                         input logic [7:0] er, input logic ev, input logic [2:0] es,
                         input logic [7:0] ed, input logic el);
        @(negedge clk);
        in_valid = iv; in_last = last; out_ready = 1'b1; in_data = pack(8'h55);
        #1;
        check_out(tag, er, ev, es, ed);
        check({tag, " out_last"}, 32'(out_last), 32'(el));
    endtask
`endif

    initial begin
        logic [2:0] s;

        // ---- vector table: inputs for one cycle, expected state before the edge
        // All lanes valid, draining every cycle: strict rotation, no bubbles.
        for (int i = 0; i < 16; i++) begin
            s = (i == 0) ? 3'd0 : 3'((i - 1) % 8);
            add(0, 8'hFF, 1, 8'h55, 8'd1 << (i % 8), (i != 0), s, 8'(s) * 8'h11);
        end
        // Backpressure: frozen output, nothing accepted.
        for (int i = 0; i < 5; i++) add(0, 8'hFF, 0, 8'h55, 8'h00, 1, 3'd7, 8'h77);
        add(0, 8'hFF, 1, 8'h55, 8'h01, 1, 3'd7, 8'h77);   // release: reload same cycle
        add(0, 8'h00, 1, 8'h55, 8'h00, 1, 3'd0, 8'h00);
        add(0, 8'h00, 1, 8'h55, 8'h00, 0, 3'd0, 8'h00);
        // Move ptr to 3, then lanes 7 and 2: 7 first, ptr wraps, then 2.
        add(0, 8'h04, 1, 8'h55, 8'h04, 0, 3'd0, 8'h00);
        add(0, 8'h84, 1, 8'h55, 8'h80, 1, 3'd2, 8'h22);
        add(0, 8'h84, 1, 8'h55, 8'h04, 1, 3'd7, 8'h77);
        add(0, 8'h00, 1, 8'h55, 8'h00, 1, 3'd2, 8'h22);
        add(0, 8'h00, 1, 8'h55, 8'h00, 0, 3'd2, 8'h22);
        // Single lane 5, back-to-back with changing data.
        add(0, 8'h20, 1, 8'hA5, 8'h20, 0, 3'd2, 8'h22);
        add(0, 8'h20, 1, 8'h5A, 8'h20, 1, 3'd5, 8'hA5);
        add(0, 8'h00, 1, 8'h55, 8'h00, 1, 3'd5, 8'h5A);
        add(0, 8'h00, 1, 8'h55, 8'h00, 0, 3'd5, 8'h5A);
        // Fill the output, stall, then reset mid-stream.
        add(0, 8'hFF, 0, 8'h55, 8'h40, 0, 3'd5, 8'h5A);
        add(0, 8'hFF, 0, 8'h55, 8'h00, 1, 3'd6, 8'h66);
        add(1, 8'hFF, 0, 8'h55, 8'h00, 0, 3'd0, 8'h00);
        add(0, 8'h28, 1, 8'h55, 8'h08, 0, 3'd0, 8'h00);   // ptr back at 0
        add(0, 8'h00, 1, 8'h55, 8'h00, 1, 3'd3, 8'h33);

        // ---- reset state
        rst = 1'b1; in_valid = 8'hFF; out_ready = 1'b1; in_data = pack(8'h55);
`ifdef RR_MUX8_LOCK_EN
        in_last = 8'hFF;
`endif
        @(negedge clk);
        @(negedge clk);
        #1;
        check_out("reset", 8'h00, 1'b0, 3'd0, 8'h00);

        // ---- table
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst       = tbl[i].rst;
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            in_data   = pack(tbl[i].d5);
            #1;
            check_out($sformatf("vec%0d", i), tbl[i].er, tbl[i].ev, tbl[i].es, tbl[i].ed);
        end

        // ---- in_valid changes within a cycle: grant re-evaluated, ptr still 4
        @(negedge clk);
        in_valid = 8'h82; out_ready = 1'b1;
        #1;
        check("reeval a in_ready", 32'(in_ready), 32'h80);
        in_valid = 8'h02;
        #1;
        check("reeval b in_ready", 32'(in_ready), 32'h02);
        @(negedge clk);
        in_valid = 8'h82;
        #1;
        check_out("reeval c", 8'h80, 1'b1, 3'd1, 8'h11);
        @(negedge clk);
        in_valid = 8'h00;
        #1;
        check_out("reeval d", 8'h00, 1'b1, 3'd7, 8'h77);

`ifdef RR_MUX8_LOCK_EN
        // ---- packet lock: lane 1 sends last=0,0,1 with a gap; lane 0 waits
        @(negedge clk);
        rst = 1'b1; in_valid = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        lstep("lock0", 8'h01, 8'hFF, 8'h01, 0, 3'd0, 8'h00, 0);
        lstep("lock1", 8'h03, 8'hFD, 8'h02, 1, 3'd0, 8'h00, 1);
        lstep("lock2", 8'h01, 8'hFD, 8'h00, 1, 3'd1, 8'h11, 0);
        lstep("lock3", 8'h03, 8'hFD, 8'h02, 0, 3'd1, 8'h11, 0);
        lstep("lock4", 8'h03, 8'hFF, 8'h02, 1, 3'd1, 8'h11, 0);
        lstep("lock5", 8'h01, 8'hFF, 8'h01, 1, 3'd1, 8'h11, 1);
        lstep("lock6", 8'h00, 8'hFF, 8'h00, 1, 3'd0, 8'h00, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
